// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, serial one-bit-per-cycle shifts,
// result returned over a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready high (after the first edge out of reset)
// SHIFT | serial shift in progress; result register doubles as shift register
// DONE  | result final; out_valid follows one edge later with the registered zero compare
module alu_exec #(
  parameter int DWIDTH = 32,
  parameter int SWIDTH = 4,
  parameter int SHW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] alu_sel,
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam logic [SWIDTH-1:0] SEL_ADD  = SWIDTH'(4'b0000);
  localparam logic [SWIDTH-1:0] SEL_SUB  = SWIDTH'(4'b0001);
  localparam logic [SWIDTH-1:0] SEL_SLL  = SWIDTH'(4'b0010);
  localparam logic [SWIDTH-1:0] SEL_SLT  = SWIDTH'(4'b0100);
  localparam logic [SWIDTH-1:0] SEL_SLTU = SWIDTH'(4'b0110);
  localparam logic [SWIDTH-1:0] SEL_XOR  = SWIDTH'(4'b1000);
  localparam logic [SWIDTH-1:0] SEL_SRL  = SWIDTH'(4'b1010);
  localparam logic [SWIDTH-1:0] SEL_SRA  = SWIDTH'(4'b1011);
  localparam logic [SWIDTH-1:0] SEL_OR   = SWIDTH'(4'b1100);
  localparam logic [SWIDTH-1:0] SEL_AND  = SWIDTH'(4'b1110);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [SWIDTH-1:0] sel_q;
  logic [SHW-1:0]    cnt;
  logic [SHW-1:0]    shamt;
  logic [DWIDTH-1:0] alu_res;
  logic [DWIDTH-1:0] shift_step;
  logic              legal;
  logic              is_shift;
  logic              accept;
  logic              pop;
  logic              start_shift;

  assign accept      = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign shamt       = op_b[SHW-1:0];
  assign is_shift    = (alu_sel == SEL_SLL) || (alu_sel == SEL_SRL) || (alu_sel == SEL_SRA);
  assign start_shift = is_shift && (shamt != '0);

  // Shift ops report op_a here so a zero-amount shift completes like a one-cycle op.
  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (alu_sel)
      SEL_ADD:  alu_res = op_a + op_b;
      SEL_SUB:  alu_res = op_a - op_b;
      SEL_SLT:  alu_res = DWIDTH'($signed(op_a) < $signed(op_b));
      SEL_SLTU: alu_res = DWIDTH'(op_a < op_b);
      SEL_XOR:  alu_res = op_a ^ op_b;
      SEL_OR:   alu_res = op_a | op_b;
      SEL_AND:  alu_res = op_a & op_b;
      SEL_SLL, SEL_SRL, SEL_SRA: alu_res = op_a;
      default: begin
        alu_res = '0;
        legal   = 1'b0;
      end
    endcase
  end

  always_comb begin
    shift_step = result;
    case (sel_q)
      SEL_SLL: shift_step = {result[DWIDTH-2:0], 1'b0};
      SEL_SRL: shift_step = {1'b0, result[DWIDTH-1:1]};
      SEL_SRA: shift_step = {result[DWIDTH-1], result[DWIDTH-1:1]};
      default: shift_step = result;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SHW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (pop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      sel_q     <= '0;
      cnt       <= '0;
    end else begin
      in_ready <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            sel_q   <= alu_sel;
            illegal <= ~legal;
            result  <= alu_res;
            cnt     <= start_shift ? shamt : '0;
          end
        end
        SHIFT: begin
          result <= shift_step;
          cnt    <= cnt - SHW'(1);
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            zero      <= (result == '0);
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed bench for alu_exec against a behavioural reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: result from plain arithmetic, latency = 1 cycle plus one per shifted bit.
  task automatic ref_model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ill, output int lat);
    int amt;
    amt = int'(b % 32);
    ill = 1'b0;
    lat = 1;
    case (sel)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  begin r = a << amt; lat = 1 + amt; end
      4'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a ^ b;
      4'd10: begin r = a >> amt; lat = 1 + amt; end
      4'd11: begin r = 32'($signed(a) >>> amt); lat = 1 + amt; end
      4'd12: r = a | b;
      4'd14: r = a & b;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          cycles;
    ref_model(sel, a, b, er, eill, elat);
    @(negedge clk);
    check_val({tag, ".rdy_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    alu_sel   = sel;
    op_a      = a;
    op_b      = b;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    alu_sel  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    check_val({tag, ".busy"}, in_ready, 0);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) begin
      check_val({tag, ".timeout"}, 0, 1);
      return;
    end
    check_val({tag, ".lat"}, cycles, elat);
    check_val({tag, ".res"}, result, er);
    check_val({tag, ".zero"}, zero, (er == 0));
    check_val({tag, ".ill"}, illegal, eill);
    if (stall > 0) begin
      in_valid = 1'b1;
      alu_sel  = 4'd0;
      op_a     = $urandom;
      op_b     = $urandom;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check_val({tag, ".hold_v"}, out_valid, 1);
        check_val({tag, ".hold_r"}, result, er);
        check_val({tag, ".hold_rdy"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_val({tag, ".pop_v"}, out_valid, 0);
    check_val({tag, ".pop_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] legal_sel [10];
    legal_sel = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd11, 4'd12, 4'd14};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    alu_sel   = 4'd0;
    op_a      = 32'd1;
    op_b      = 32'd2;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst.rdy", in_ready, 0);
    check_val("rst.v", out_valid, 0);
    check_val("rst.res", result, 0);
    check_val("rst.zero", zero, 0);
    check_val("rst.ill", illegal, 0);
    rst_n = 1'b1;
    #1;
    check_val("rel.rdy0", in_ready, 0);
    @(negedge clk);
    check_val("rel.rdy1", in_ready, 1);
    check_val("rel.v", out_valid, 0);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rel.novalid", out_valid, 0);
      check_val("rel.rdy", in_ready, 1);
    end

    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sub", 4'd1, 32'd5, 32'd7, 0);
    do_op("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sra31", 4'd11, 32'h8000_0000, 32'd31, 0);
    do_op("srl4", 4'd10, 32'h8000_0000, 32'h24, 0);
    do_op("sll0", 4'd2, 32'h1234_5678, 32'h40, 0);
    do_op("illegal", 4'd3, 32'hDEAD_BEEF, 32'h1, 0);
    do_op("xor_bp", 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
    do_op("after_bp", 4'd0, 32'd10, 32'd20, 0);

    // Reset in the middle of a 20-bit left shift.
    @(negedge clk);
    in_valid = 1'b1;
    alu_sel  = 4'd2;
    op_a     = 32'h0000_0F0F;
    op_b     = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid.v", out_valid, 0);
    check_val("mid.res", result, 0);
    check_val("mid.rdy", in_ready, 0);
    check_val("mid.zero", zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check_val("mid.noresult", out_valid, 0);
    end
    do_op("post_rst_add", 4'd0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      if ($urandom_range(0, 7) == 0) begin
        s = 4'($urandom);
      end else begin
        s = legal_sel[$urandom_range(0, 9)];
      end
      do_op($sformatf("rnd%0d", i), s, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
